// File: rtl/matmul_tile_bank_ctrl.sv
// Memory and sequencing controller for a TILES x TILES grid of systolic matmul
// building blocks: host load path into the A/B banks, run start/stop, and a
// back-pressured drain of the C row banks through a small output FIFO.
module matmul_tile_bank_ctrl #(
  parameter int DWIDTH     = 16,
  parameter int BB         = 4,
  parameter int AWIDTH     = 7,
  parameter int TILES      = 2,
  parameter int BANK_W     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic                          host_wr_sel,
  input  logic [BANK_W-1:0]             host_wr_bank,
  input  logic [AWIDTH-1:0]             host_wr_addr,
  input  logic [BB*DWIDTH-1:0]          host_wr_data,
  input  logic                          start,
  input  logic [AWIDTH-1:0]             num_rows,
  output logic                          busy,
  output logic                          done,
  output logic                          mm_start,
  input  logic                          mm_done,
  input  logic [TILES*AWIDTH-1:0]       mm_a_addr,
  input  logic [TILES*AWIDTH-1:0]       mm_b_addr,
  output logic [TILES*AWIDTH-1:0]       a_ram_addr,
  output logic [TILES-1:0]              a_ram_we,
  output logic [TILES*AWIDTH-1:0]       b_ram_addr,
  output logic [TILES-1:0]              b_ram_we,
  output logic [BB*DWIDTH-1:0]          ram_wdata,
  output logic [AWIDTH-1:0]             c_ram_addr,
  input  logic [TILES*BB*DWIDTH-1:0]    c_ram_q,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [BB*DWIDTH-1:0]          rd_data,
  output logic                          rd_last
);

  localparam int WW = BB * DWIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state, next_state;
  logic                alive;
  logic [AWIDTH-1:0]   nrows_q;
  logic [AWIDTH-1:0]   c_addr;
  logic [AWIDTH-1:0]   rd_cnt;
  logic                wr_accept;
  logic                issue, issue_d1, or_vld, push, pop;
  logic [WW-1:0]       bank_or, or_q;
  logic [WW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_idx, rd_idx;
  logic [PW:0]         fifo_cnt;
  logic [OW-1:0]       occ_total;

  assign wr_accept  = host_wr_valid && host_wr_ready;
  assign c_ram_addr = c_addr;
  assign push       = or_vld;
  assign pop        = rd_valid && rd_ready;
  assign rd_valid   = (fifo_cnt != '0);
  assign rd_data    = rd_valid ? fifo_mem[rd_idx] : '0;
  assign rd_last    = rd_valid && (rd_cnt == nrows_q - AWIDTH'(1));

  // Reads in the RAM and OR stages count against FIFO space so a push never overflows.
  assign occ_total  = OW'(fifo_cnt) + OW'(issue_d1) + OW'(or_vld);
  assign issue      = (state == DRAIN) && (c_addr < nrows_q) && (occ_total < OW'(FIFO_DEPTH));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and control outputs; start takes priority over a host write in IDLE.
  always_comb begin
    next_state    = state;
    busy          = (state != IDLE);
    done          = (state == FIN);
    mm_start      = (state == RUN);
    host_wr_ready = 1'b0;
    case (state)
      IDLE: begin
        host_wr_ready = alive && !start;
        if (start) next_state = RUN;
      end
      RUN: begin
        if (mm_done) next_state = (nrows_q == '0) ? FIN : DRAIN;
      end
      DRAIN: begin
        if (pop && rd_last) next_state = FIN;
      end
      FIN: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered A/B bank addresses, write enables and write data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_ram_addr <= '0;
      b_ram_addr <= '0;
      a_ram_we   <= '0;
      b_ram_we   <= '0;
      ram_wdata  <= '0;
    end else begin
      a_ram_we <= '0;
      b_ram_we <= '0;
      if (state == RUN) begin
        a_ram_addr <= mm_a_addr;
        b_ram_addr <= mm_b_addr;
      end
      if (wr_accept) begin
        ram_wdata <= host_wr_data;
        for (int i = 0; i < TILES; i++) begin
          if (32'(host_wr_bank) == i) begin
            if (!host_wr_sel) begin
              a_ram_we[i]                   <= 1'b1;
              a_ram_addr[i*AWIDTH +: AWIDTH] <= host_wr_addr;
            end else begin
              b_ram_we[i]                   <= 1'b1;
              b_ram_addr[i*AWIDTH +: AWIDTH] <= host_wr_addr;
            end
          end
        end
      end
    end
  end

  // Run bookkeeping: row count, C address (run counter, then drain pointer), beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alive   <= 1'b0;
      nrows_q <= '0;
      c_addr  <= '0;
      rd_cnt  <= '0;
    end else begin
      alive <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            nrows_q <= num_rows;
            c_addr  <= '0;
            rd_cnt  <= '0;
          end
        end
        RUN: begin
          if (mm_done) c_addr <= '0;
          else         c_addr <= c_addr + AWIDTH'(1);
        end
        DRAIN: begin
          if (issue) c_addr <= c_addr + AWIDTH'(1);
          if (pop)   rd_cnt <= rd_cnt + AWIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Merge the C bank words read in the previous cycle.
  always_comb begin
    bank_or = '0;
    for (int i = 0; i < TILES; i++) bank_or = bank_or | c_ram_q[i*WW +: WW];
  end

  // Read pipeline: issue -> RAM data -> OR register -> FIFO push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_d1 <= 1'b0;
      or_vld   <= 1'b0;
      or_q     <= '0;
    end else begin
      issue_d1 <= issue;
      or_vld   <= issue_d1;
      if (issue_d1) or_q <= bank_or;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + PW'(1);
      if (pop)  rd_idx <= rd_idx + PW'(1);
      fifo_cnt <= fifo_cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // FIFO storage; contents are only visible through rd_data while rd_valid is high.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= or_q;
  end

endmodule

// File: tb/tb_matmul_tile_bank_ctrl.sv
// Directed self-checking bench for matmul_tile_bank_ctrl with default parameters.
module tb_matmul_tile_bank_ctrl;

  logic         clk;
  logic         reset_n;
  logic         host_wr_valid;
  logic         host_wr_ready;
  logic         host_wr_sel;
  logic [0:0]   host_wr_bank;
  logic [6:0]   host_wr_addr;
  logic [63:0]  host_wr_data;
  logic         start;
  logic [6:0]   num_rows;
  logic         busy;
  logic         done;
  logic         mm_start;
  logic         mm_done;
  logic [13:0]  mm_a_addr;
  logic [13:0]  mm_b_addr;
  logic [13:0]  a_ram_addr;
  logic [1:0]   a_ram_we;
  logic [13:0]  b_ram_addr;
  logic [1:0]   b_ram_we;
  logic [63:0]  ram_wdata;
  logic [6:0]   c_ram_addr;
  logic [127:0] c_ram_q;
  logic         rd_valid;
  logic         rd_ready;
  logic [63:0]  rd_data;
  logic         rd_last;

  int checks;
  int failures;

  matmul_tile_bank_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_sel(host_wr_sel), .host_wr_bank(host_wr_bank),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .start(start), .num_rows(num_rows), .busy(busy), .done(done),
    .mm_start(mm_start), .mm_done(mm_done),
    .mm_a_addr(mm_a_addr), .mm_b_addr(mm_b_addr),
    .a_ram_addr(a_ram_addr), .a_ram_we(a_ram_we),
    .b_ram_addr(b_ram_addr), .b_ram_we(b_ram_we),
    .ram_wdata(ram_wdata), .c_ram_addr(c_ram_addr), .c_ram_q(c_ram_q),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // C bank contents: row 0 splits its bits between the banks, other rows put the row number in each byte half.
  function automatic logic [63:0] bank0_row(int a);
    if (a == 0) return {4{16'h00FF}};
    return {4{8'h00, 8'(a)}};
  endfunction

  function automatic logic [63:0] bank1_row(int a);
    if (a == 0) return {4{16'hFF00}};
    return {4{8'(a), 8'h00}};
  endfunction

  function automatic logic [63:0] exp_row(int a);
    if (a == 0) return {4{16'hFFFF}};
    return {4{8'(a), 8'(a)}};
  endfunction

  // One-cycle synchronous-read model of the two C banks.
  always @(posedge clk) c_ram_q <= {bank1_row(int'(c_ram_addr)), bank0_row(int'(c_ram_addr))};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Services the drain from its first cycle until done is seen or the budget runs out.
  task automatic run_drain(input int n, input bit bp, output int beats, output int first_valid,
                           output int dones, output int max_out, output int unstable);
    logic [63:0] prev_data;
    bit          prev_stall;
    beats = 0; first_valid = -1; dones = 0; max_out = 0; unstable = 0;
    prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rd_ready = bp ? (((cyc % 4) == 0) || ((cyc % 4) == 3)) : 1'b1;
      #1;
      if (prev_stall && !(rd_valid === 1'b1 && rd_data === prev_data)) unstable++;
      if (busy && !done && (int'(c_ram_addr) - beats > max_out)) max_out = int'(c_ram_addr) - beats;
      if (rd_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        check_output($sformatf("beat%0d_data", beats), rd_data, exp_row(beats));
        check_output($sformatf("beat%0d_last", beats), 64'(rd_last), 64'(beats == n - 1));
        prev_stall = !rd_ready;
        prev_data  = rd_data;
        if (rd_ready) beats++;
      end else begin
        prev_stall = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        break;
      end
      @(posedge clk);
      #1;
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    int beats, first_valid, dones, max_out, unstable;
    checks = 0; failures = 0;
    reset_n = 1'b0; host_wr_valid = 1'b0; host_wr_sel = 1'b0; host_wr_bank = '0;
    host_wr_addr = '0; host_wr_data = '0; start = 1'b0; num_rows = '0; mm_done = 1'b0;
    mm_a_addr = '0; mm_b_addr = '0; rd_ready = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_wr_ready", 64'(host_wr_ready), 64'd0);
    check_output("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_output("rst_mm_start", 64'(mm_start), 64'd0);
    check_output("rst_a_we", 64'(a_ram_we), 64'd0);
    reset_n = 1'b1;
    tick();
    tick();

    // Host load: A bank 1, address 5.
    host_wr_valid = 1'b1; host_wr_sel = 1'b0; host_wr_bank = 1'b1;
    host_wr_addr = 7'd5; host_wr_data = 64'h1111_2222_3333_4444;
    #1;
    check_output("load_ready", 64'(host_wr_ready), 64'd1);
    tick();
    host_wr_valid = 1'b0;
    check_output("load_a_we", 64'(a_ram_we), 64'b10);
    check_output("load_a_addr1", 64'(a_ram_addr[13:7]), 64'd5);
    check_output("load_a_addr0", 64'(a_ram_addr[6:0]), 64'd0);
    check_output("load_wdata", ram_wdata, 64'h1111_2222_3333_4444);
    check_output("load_b_we", 64'(b_ram_we), 64'd0);

    // Host load: B bank 0, address 9.
    host_wr_valid = 1'b1; host_wr_sel = 1'b1; host_wr_bank = 1'b0;
    host_wr_addr = 7'd9; host_wr_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    host_wr_valid = 1'b0;
    check_output("loadb_b_we", 64'(b_ram_we), 64'b01);
    check_output("loadb_b_addr0", 64'(b_ram_addr[6:0]), 64'd9);
    check_output("loadb_a_we", 64'(a_ram_we), 64'd0);
    check_output("loadb_wdata", ram_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    check_output("loadb_we_pulse", 64'(b_ram_we), 64'd0);

    // Start together with a host write: start wins, write is refused.
    mm_a_addr = {7'd33, 7'd17}; mm_b_addr = {7'd44, 7'd22};
    num_rows = 7'd4; start = 1'b1;
    host_wr_valid = 1'b1; host_wr_sel = 1'b0; host_wr_bank = 1'b0; host_wr_addr = 7'd3;
    #1;
    check_output("startwr_ready", 64'(host_wr_ready), 64'd0);
    tick();
    start = 1'b0; host_wr_valid = 1'b0; num_rows = '0;
    check_output("startwr_a_we", 64'(a_ram_we), 64'd0);
    check_output("startwr_b_we", 64'(b_ram_we), 64'd0);
    check_output("run_busy", 64'(busy), 64'd1);

    // RUN for 20 cycles; mm_done on the 20th.
    for (int k = 0; k < 20; k++) begin
      check_output($sformatf("run_caddr%0d", k), 64'(c_ram_addr), 64'(k));
      check_output($sformatf("run_mmstart%0d", k), 64'(mm_start), 64'd1);
      if (k == 1) begin
        check_output("run_a_addr", 64'(a_ram_addr), 64'({7'd33, 7'd17}));
        check_output("run_b_addr", 64'(b_ram_addr), 64'({7'd44, 7'd22}));
      end
      if (k == 19) mm_done = 1'b1;
      tick();
    end
    mm_done = 1'b0;
    check_output("drain_mmstart", 64'(mm_start), 64'd0);
    check_output("drain_caddr0", 64'(c_ram_addr), 64'd0);
    run_drain(4, 1'b0, beats, first_valid, dones, max_out, unstable);
    check_output("s2_beats", 64'(beats), 64'd4);
    check_output("s2_first_valid", 64'(first_valid), 64'd3);
    check_output("s2_done", 64'(dones), 64'd1);
    check_output("s2_fin_busy", 64'(busy), 64'd1);
    tick();
    check_output("s2_done_fall", 64'(done), 64'd0);
    check_output("s2_busy_fall", 64'(busy), 64'd0);
    check_output("s2_wr_ready", 64'(host_wr_ready), 64'd1);

    // Back-pressure with rd_ready 1-0-0-1 over 10 rows.
    num_rows = 7'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    run_drain(10, 1'b1, beats, first_valid, dones, max_out, unstable);
    check_output("bp_beats", 64'(beats), 64'd10);
    check_output("bp_done", 64'(dones), 64'd1);
    check_output("bp_outstanding_ok", 64'(max_out <= 4), 64'd1);
    check_output("bp_stable", 64'(unstable), 64'd0);
    check_output("bp_first_valid", 64'(first_valid), 64'd3);
    tick();
    check_output("bp_idle", 64'(busy), 64'd0);

    // num_rows = 0: done the cycle after mm_done, no beats.
    num_rows = 7'd0; start = 1'b1;
    tick();
    start = 1'b0;
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    check_output("zero_done", 64'(done), 64'd1);
    check_output("zero_rd_valid", 64'(rd_valid), 64'd0);
    tick();
    check_output("zero_done_fall", 64'(done), 64'd0);
    check_output("zero_busy", 64'(busy), 64'd0);
    check_output("zero_rd_valid2", 64'(rd_valid), 64'd0);

    // Reset mid-drain with three beats buffered.
    num_rows = 7'd10; start = 1'b1;
    tick();
    start = 1'b0;
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    rd_ready = 1'b0;
    repeat (5) tick();
    check_output("pre_rst_valid", 64'(rd_valid), 64'd1);
    check_output("pre_rst_data", rd_data, exp_row(0));
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 64'(rd_valid), 64'd0);
    check_output("mid_rst_busy", 64'(busy), 64'd0);
    check_output("mid_rst_caddr", 64'(c_ram_addr), 64'd0);
    check_output("mid_rst_wdata", ram_wdata, 64'd0);
    check_output("mid_rst_a_addr", 64'(a_ram_addr), 64'd0);
    check_output("mid_rst_rd_data", rd_data, 64'd0);
    check_output("mid_rst_wr_ready", 64'(host_wr_ready), 64'd0);
    tick();
    tick();
    check_output("in_rst_valid", 64'(rd_valid), 64'd0);
    reset_n = 1'b1;
    tick();
    tick();
    check_output("post_rst_busy", 64'(busy), 64'd0);
    check_output("post_rst_valid", 64'(rd_valid), 64'd0);
    check_output("post_rst_wr_ready", 64'(host_wr_ready), 64'd1);

    // A fresh run after reset behaves normally.
    num_rows = 7'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check_output("rerun_caddr", 64'(c_ram_addr), 64'd0);
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    run_drain(4, 1'b0, beats, first_valid, dones, max_out, unstable);
    check_output("rerun_beats", 64'(beats), 64'd4);
    check_output("rerun_first_valid", 64'(first_valid), 64'd3);
    check_output("rerun_done", 64'(dones), 64'd1);
    tick();
    check_output("rerun_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
